// File: rtl/sipo_deser_if.sv
// Signal bundle between a serial source / parallel sink and sipo_deser.
// The slave modport is the deserializer's view; master is the environment's.
interface sipo_deser_if #(
  parameter int WIDTH = 8
) ();
  logic                       sin;
  logic                       shift;
  logic                       sync_n;
  logic [WIDTH-1:0]           shreg;
  logic [$clog2(WIDTH)-1:0]   cnt;
  logic [WIDTH-1:0]           pout;
  logic                       valid;
  logic                       ready;
  logic                       overrun;
  logic                       clr_ovr;

  modport slave (
    input  sin, shift, sync_n, ready, clr_ovr,
    output shreg, cnt, pout, valid, overrun
  );

  modport master (
    output sin, shift, sync_n, ready, clr_ovr,
    input  shreg, cnt, pout, valid, overrun
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with frame align and a valid/ready holding register.
// Define SIPO_OVERRUN_EN to drop words on back-pressure and raise a sticky overrun flag.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        nRST,
  sipo_deser_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] pout_q;
  logic             valid_q;
  logic             overrun_q;
  logic             word_done;
  logic             consume;
  logic             drop;
  logic             load;

  always_comb begin
    if (MSB_FIRST) shreg_nxt = {shreg_q[WIDTH-2:0], bus.sin};
    else           shreg_nxt = {bus.sin, shreg_q[WIDTH-1:1]};
  end

  assign word_done = bus.shift && bus.sync_n && (cnt_q == LAST);
  assign consume   = valid_q && bus.ready;

`ifdef SIPO_OVERRUN_EN
  assign drop = word_done && valid_q && !bus.ready;
`else
  assign drop = 1'b0;
`endif
  assign load = word_done && !drop;

  // Frame align wins over shift and leaves the shift register untouched.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (!bus.sync_n) begin
      cnt_q <= '0;
    end else if (bus.shift) begin
      shreg_q <= shreg_nxt;
      cnt_q   <= word_done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pout_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      pout_q  <= shreg_nxt;
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

`ifdef SIPO_OVERRUN_EN
  // A drop on the same edge as clr_ovr keeps the flag set.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)            overrun_q <= 1'b0;
    else if (drop)        overrun_q <= 1'b1;
    else if (bus.clr_ovr) overrun_q <= 1'b0;
  end
`else
  logic unused_clr_ovr;
  assign unused_clr_ovr = bus.clr_ovr;
  assign overrun_q      = 1'b0;
`endif

  assign bus.shreg   = shreg_q;
  assign bus.cnt     = cnt_q;
  assign bus.pout    = pout_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a bit-queue reference model.
module tb_sipo_deser;
  localparam int W = 8;

  logic clk = 1'b0;
  logic nRST;
  logic sin, shift, sync_n, ready, clr_ovr;

  int checks = 0;
  int errors = 0;

  bit           hist[$];
  bit           part[$];
  logic [W-1:0] m_pout_m, m_pout_l;
  bit           m_valid, m_ovr;

  sipo_deser_if #(.WIDTH(W)) bus_m ();
  sipo_deser_if #(.WIDTH(W)) bus_l ();

  assign bus_m.sin = sin;     assign bus_l.sin = sin;
  assign bus_m.shift = shift; assign bus_l.shift = shift;
  assign bus_m.sync_n = sync_n; assign bus_l.sync_n = sync_n;
  assign bus_m.ready = ready; assign bus_l.ready = ready;
  assign bus_m.clr_ovr = clr_ovr; assign bus_l.clr_ovr = clr_ovr;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .nRST(nRST), .bus(bus_m));
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .nRST(nRST), .bus(bus_l));

  always #5 clk = ~clk;

  // q[0] is the oldest bit; MSB-first puts it at the top, LSB-first at bit 0.
  function automatic logic [W-1:0] pack(input bit q[$], input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < q.size() && i < W; i++) begin
      if (msb) w[W-1-i] = q[i];
      else     w[i]     = q[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    part.delete();
    m_pout_m = '0;
    m_pout_l = '0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("shreg_m", 32'(bus_m.shreg), 32'(pack(hist, 1'b1)));
    chk("shreg_l", 32'(bus_l.shreg), 32'(pack(hist, 1'b0)));
    chk("cnt_m", 32'(bus_m.cnt), part.size());
    chk("cnt_l", 32'(bus_l.cnt), part.size());
    chk("pout_m", 32'(bus_m.pout), 32'(m_pout_m));
    chk("pout_l", 32'(bus_l.pout), 32'(m_pout_l));
    chk("valid_m", 32'(bus_m.valid), 32'(m_valid));
    chk("valid_l", 32'(bus_l.valid), 32'(m_valid));
    chk("ovr_m", 32'(bus_m.overrun), 32'(m_ovr));
    chk("ovr_l", 32'(bus_l.overrun), 32'(m_ovr));
  endtask

  task automatic tick();
    bit done;
    bit set_ovr;
    @(posedge clk);
    done    = 1'b0;
    set_ovr = 1'b0;
    if (!nRST) begin
      model_reset();
    end else begin
      if (!sync_n) begin
        part.delete();
      end else if (shift) begin
        hist.push_back(sin);
        void'(hist.pop_front());
        part.push_back(sin);
        done = (part.size() == W);
      end
      if (done && m_valid && !ready) begin
`ifdef SIPO_OVERRUN_EN
        set_ovr = 1'b1;
        m_ovr   = 1'b1;
`else
        m_pout_m = pack(part, 1'b1);
        m_pout_l = pack(part, 1'b0);
`endif
      end else if (done) begin
        m_pout_m = pack(part, 1'b1);
        m_pout_l = pack(part, 1'b0);
        m_valid  = 1'b1;
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
`ifdef SIPO_OVERRUN_EN
      if (clr_ovr && !set_ovr) m_ovr = 1'b0;
`endif
      if (done) part.delete();
    end
    #1;
    check_all();
  endtask

  task automatic send(input logic [W-1:0] w);
    shift = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      sin = w[i];
      tick();
    end
    shift = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; sin = 1'b0; shift = 1'b1; sync_n = 1'b1; ready = 1'b1; clr_ovr = 1'b0;
    model_reset();

    // Reset held while the stream is running
    for (int i = 0; i < 4; i++) begin
      sin = i[0];
      tick();
    end
    chk("rst_pout", 32'(bus_m.pout), 32'h0);
    chk("rst_valid", 32'(bus_m.valid), 32'h0);
    nRST = 1'b1;
    send(8'hC3);
    chk("align_rel", 32'(bus_m.pout), 32'hC3);
    chk("align_rel_v", 32'(bus_m.valid), 32'h1);

    // Consecutive words, ready high
    send(8'hA5);
    chk("a5_pout", 32'(bus_m.pout), 32'hA5);
    chk("a5_valid", 32'(bus_m.valid), 32'h1);
    chk("a5_cnt", 32'(bus_m.cnt), 32'h0);
    tick();
    chk("a5_consumed", 32'(bus_m.valid), 32'h0);

    send(8'b0001_0010);
    chk("lsb_48", 32'(bus_l.pout), 32'h48);
    chk("lsb_valid", 32'(bus_l.valid), 32'h1);
    tick();

    // Frame align discards a partial word
    shift = 1'b1; sin = 1'b1;
    repeat (3) tick();
    sync_n = 1'b0;
    tick();
    chk("sync_cnt", 32'(bus_m.cnt), 32'h0);
    chk("sync_novalid", 32'(bus_m.valid), 32'h0);
    sync_n = 1'b1;
    send(8'h5A);
    chk("sync_5a", 32'(bus_m.pout), 32'h5A);
    tick();

    // Back-pressure
    ready = 1'b0;
    send(8'h11);
    chk("bp_11", 32'(bus_m.pout), 32'h11);
    send(8'h22);
`ifdef SIPO_OVERRUN_EN
    chk("bp_keep", 32'(bus_m.pout), 32'h11);
    chk("bp_ovr", 32'(bus_m.overrun), 32'h1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("bp_clr", 32'(bus_m.overrun), 32'h0);
`else
    chk("bp_over", 32'(bus_m.pout), 32'h22);
    chk("bp_noovr", 32'(bus_m.overrun), 32'h0);
`endif
    chk("bp_valid", 32'(bus_m.valid), 32'h1);
    ready = 1'b1;
    tick();
    chk("bp_consume", 32'(bus_m.valid), 32'h0);

    // Consume and complete on the same edge
    ready = 1'b0;
    send(8'h33);
    chk("cc_33", 32'(bus_m.pout), 32'h33);
    shift = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      sin   = 1'(8'h44 >> i);
      ready = (i == 0);
      tick();
    end
    shift = 1'b0;
    chk("cc_44", 32'(bus_m.pout), 32'h44);
    chk("cc_valid", 32'(bus_m.valid), 32'h1);
    tick();
    chk("cc_drain", 32'(bus_m.valid), 32'h0);

    // Randomized traffic with one asynchronous reset mid-word
    for (int n = 0; n < 600; n++) begin
      sin     = 1'($urandom_range(0, 1));
      shift   = ($urandom_range(0, 3) != 0);
      sync_n  = ($urandom_range(0, 19) != 0);
      ready   = 1'($urandom_range(0, 1));
      clr_ovr = ($urandom_range(0, 15) == 0);
      if (n == 300) begin
        #2 nRST = 1'b0;
        #1 model_reset();
        check_all();
        #1 nRST = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in/parallel-out deserializer, the receive-side counterpart of the ls166 pixel shifter: it assembles a serial bit stream into WIDTH-bit words. It sits between any serial source (a ROM/PROM bit stream, a sound or protection-MCU serial link, a test-pattern shifter) and the parallel bus logic. Completed words are held in a register and offered downstream with a valid/ready handshake. A frame-sync input aligns word boundaries, and an optional sticky overrun flag is available.

## Interface
- WIDTH, 8, word width in bits; legal range 2..16.
- MSB_FIRST, 1, 1 = the first received bit lands in the MSB; 0 = the first received bit lands in the LSB.

- clk  in  1  system clock; all state changes on the rising edge.
- nRST  in  1  reset, asynchronous and active-low.
- sin  in  1  serial data bit, sampled when shift=1.
- shift  in  1  bit enable; one bit is accepted per clk edge while high.
- sync_n  in  1  synchronous, active-low frame align; clears the bit counter and discards any partial word.
- shreg  out  WIDTH  live shift-register contents (ls164-style taps).
- cnt  out  $clog2(WIDTH)  number of bits accepted in the current word.
- pout  out  WIDTH  holding register with the last completed word.
- valid  out  1  pout holds an unconsumed word.
- ready  in  1  downstream accepts pout when valid&&ready at the clk edge.
- overrun  out  1  sticky flag: a completed word was dropped (only with the macro).
- clr_ovr  in  1  synchronous clear of overrun.

## Operation
- Reset (nRST=0, asynchronous): shreg=0, cnt=0, pout=0, valid=0, overrun=0.
- Priority at each edge: sync_n=0 first, then shift.
- sync_n=0 at an edge:
  - cnt<=0.
  - shreg is not updated and shift is ignored that cycle.
  - The holding register, valid and overrun are unaffected.
- shift=1, sync_n=1:
  - MSB_FIRST=1: shreg<={shreg[WIDTH-2:0],sin}.
  - MSB_FIRST=0: shreg<={sin,shreg[WIDTH-1:1]}.
  - cnt<=cnt+1.
- Word complete: shift=1, sync_n=1 and cnt==WIDTH-1.
  - The candidate word is the next shreg value, including the current sin bit.
  - cnt wraps to 0.
- Load rule on word complete: if valid==0, or valid&&ready, then pout<=word and valid<=1.
- Consume without a new word: valid&&ready clears valid. pout keeps its value.
- Simultaneous consume and complete: valid stays 1 and pout takes the new word.
- Complete while valid&&!ready: overrun case, handled per Configuration.
- shift=0, sync_n=1: shreg and cnt hold.

## Timing
- Latency: the edge that samples the final bit also loads pout and sets valid, so both are visible in the following cycle.
- Maximum sustained throughput is one word per WIDTH cycles with ready tied high.
- ready is sampled only at the clk edge. valid never depends combinationally on ready.
- clr_ovr and a same-edge overrun set: set wins, overrun=1.
- nRST asserted mid-word: all state clears immediately. The partial word is lost and the next bit starts at cnt=0.

## Configuration
- SIPO_OVERRUN_EN defined:
  - On an overrun case the new word is dropped and pout keeps the old word.
  - overrun<=1 and stays set until a clr_ovr edge.
- SIPO_OVERRUN_EN undefined:
  - On an overrun case the new word overwrites pout and valid stays 1.
  - overrun is tied to 0 and clr_ovr is ignored.

## Test plan
- Reset: hold nRST=0 with shift=1 and toggling sin → shreg=0, cnt=0, pout=0, valid=0, overrun=0. Release nRST mid-stream, then shift 8 bits → first word is aligned from the release.
- MSB_FIRST=1, WIDTH=8, ready=1: shift bits 1,0,1,0,0,1,0,1 on consecutive edges → cycle after the 8th edge pout=0xA5, valid=1 for one cycle, cnt=0.
- MSB_FIRST=0: shift bits 0,0,0,1,0,0,1,0 → pout=0x48, valid=1.
- Frame align: shift 3 bits of 1, pulse sync_n=0 with shift=1, then shift 0x5A MSB-first → pout=0x5A. No word is produced from the partial bits.
- Back-pressure with ready=0: shift 0x11 then 0x22.
  - Macro defined: pout=0x11, overrun=1. A clr_ovr pulse clears overrun. Raising ready consumes 0x11.
  - Macro undefined: pout=0x22, overrun=0.
- Consume and complete on the same edge: valid=1 (pout=0x33), ready=1 on the edge completing 0x44 → valid stays 1, pout=0x44. Next ready edge → valid=0.
